// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and helpers for the cpu_run_ctrl run controller.
// Provides the FSM state enum, the reset-hold counter width and a saturating increment.
// Pure declarations; no logic, no latency, no flow control.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    LAUNCH,
    RUN,
    DONE
  } run_state_t;

  // Reset-hold counter must be able to hold the value RST_CYCLES.
  localparam int RST_CYCLES_DEF = 4;
  localparam int RST_CNT_W_DEF  = $clog2(RST_CYCLES_DEF + 1);

  function automatic int rst_cnt_w(input int rst_cycles);
    return (rst_cycles < 1) ? 1 : $clog2(rst_cycles + 1);
  endfunction

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/cpu_run_wdog.sv
// Run-cycle counter with saturation and watchdog compare for cpu_run_ctrl.
// Counter updates one cycle after en; fire is combinational from the current count.
// No backpressure: clr has priority over en; count holds when en is low.
//
// Ports: clk/rst (sync, active high), clr zeroes the count, en counts one RUN cycle,
// cycle_count is the registered count, fire flags that this cycle's increment
// reaches TIMEOUT-1.
module cpu_run_wdog
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             fire
);

  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = CNT_W'(sat_inc(64'(cycle_count), CNT_W));

  // The watchdog trips in the RUN cycle after which cycle_count reads TIMEOUT-1,
  // so a timed-out run reports exactly TIMEOUT-1 cycles.
  assign fire = (cnt_inc == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (clr) begin
      cycle_count <= '0;
    end else if (en) begin
      cycle_count <= cnt_inc;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: resets, launches and watches N sequential MIPS cores until all halt.
// Outputs are registered; reaction to go/abort/core_halt is visible one cycle later.
// No backpressure: go outside IDLE/DONE is dropped; abort beats go in the same cycle.
//
// Ports: clk, rst (sync, active high); go/go_addr/go_mask request a run; abort cancels;
// core_rst/core_start/core_addr drive the cores; core_halt reports halts; busy/done/
// timeout/halted_mask/cycle_count report status. Optional build macro
// CPU_RUN_CTRL_STAMP_EN adds halt_stamp (per-core cycle_count at first halt).
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int N_CORES    = 1,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [ADDR_W-1:0]  go_addr,
  input  logic [N_CORES-1:0] go_mask,
  input  logic               abort,
  output logic [N_CORES-1:0] core_rst,
  output logic [N_CORES-1:0] core_start,
  output logic [ADDR_W-1:0]  core_addr,
  input  logic [N_CORES-1:0] core_halt,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [N_CORES-1:0] halted_mask,
  output logic [CNT_W-1:0]   cycle_count
`ifdef CPU_RUN_CTRL_STAMP_EN
  ,
  output logic [N_CORES-1:0][CNT_W-1:0] halt_stamp
`endif
);

  localparam int RCW = rst_cnt_w(RST_CYCLES);

  run_state_t         state, state_n;
  logic [N_CORES-1:0] run_mask, run_mask_n;
  logic [RCW-1:0]     rst_cnt, rst_cnt_n;

  logic [N_CORES-1:0] core_rst_n, core_start_n, halted_mask_n;
  logic [ADDR_W-1:0]  core_addr_n;
  logic               busy_n, done_n, timeout_n;

  logic               go_acc, abort_acc, cnt_en, wd_fire, all_halt;
  logic [N_CORES-1:0] halt_hit;

  // go is only honoured from a resting state, and never alongside abort.
  assign go_acc    = go && !abort && ((state == IDLE) || (state == DONE));
  assign abort_acc = abort && (state != IDLE);
  assign halt_hit  = halted_mask | (core_halt & run_mask);
  assign all_halt  = (halt_hit == run_mask);
  assign cnt_en    = (state == RUN) && !abort_acc;

  cpu_run_wdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .clr         (go_acc),
    .en          (cnt_en),
    .cycle_count (cycle_count),
    .fire        (wd_fire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (go_acc) begin
          state_n = (go_mask == '0) ? DONE : RST_HOLD;
        end
      end
      RST_HOLD: begin
        if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
          state_n = LAUNCH;
        end
      end
      LAUNCH: state_n = RUN;
      RUN: begin
        if (all_halt || wd_fire) begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort_acc) begin
      state_n = IDLE;
    end
  end

  // Output logic: next values of every registered output, keyed off state_n so the
  // registered outputs line up with the state they describe.
  always_comb begin
    run_mask_n    = go_acc ? go_mask : run_mask;
    core_addr_n   = go_acc ? go_addr : core_addr;
    rst_cnt_n     = rst_cnt;
    done_n        = done;
    timeout_n     = timeout;
    halted_mask_n = halted_mask;

    // Once launched, selected cores leave reset and stay out of it through DONE so
    // their final architectural state can be inspected.
    if ((state_n == LAUNCH) || (state_n == RUN) || (state_n == DONE)) begin
      core_rst_n = ~run_mask_n;
    end else begin
      core_rst_n = '1;
    end
    core_start_n = (state_n == LAUNCH) ? run_mask_n : '0;
    busy_n       = (state_n == RST_HOLD) || (state_n == LAUNCH) || (state_n == RUN);

    if (state == RST_HOLD) begin
      rst_cnt_n = rst_cnt + RCW'(1);
    end

    if (abort_acc) begin
      done_n    = 1'b0;
      timeout_n = 1'b0;
    end else if (go_acc) begin
      rst_cnt_n     = '0;
      done_n        = (go_mask == '0);
      timeout_n     = 1'b0;
      halted_mask_n = '0;
    end else if (state == RUN) begin
      halted_mask_n = halt_hit;
      if (state_n == DONE) begin
        done_n    = 1'b1;
        timeout_n = !all_halt;  // completion wins over a same-cycle watchdog
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_mask    <= '0;
      rst_cnt     <= '0;
      core_rst    <= '1;
      core_start  <= '0;
      core_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      halted_mask <= '0;
    end else begin
      run_mask    <= run_mask_n;
      rst_cnt     <= rst_cnt_n;
      core_rst    <= core_rst_n;
      core_start  <= core_start_n;
      core_addr   <= core_addr_n;
      busy        <= busy_n;
      done        <= done_n;
      timeout     <= timeout_n;
      halted_mask <= halted_mask_n;
    end
  end

`ifdef CPU_RUN_CTRL_STAMP_EN
  // Stamp with the value cycle_count takes at the end of the halting cycle, so the
  // last core to halt carries the same number as the final cycle_count.
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = CNT_W'(sat_inc(64'(cycle_count), CNT_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_stamp <= '0;
    end else if (go_acc) begin
      halt_stamp <= '0;
    end else if (cnt_en) begin
      for (int i = 0; i < N_CORES; i++) begin
        if (run_mask[i] && core_halt[i] && !halted_mask[i]) begin
          halt_stamp[i] <= cnt_inc;
        end
      end
    end
  end
`endif

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run controller for one or more sequential (multicycle) MIPS cores.
- On a `go` request it holds the selected cores in reset, launches them at a programmable start address, and counts cycles until every selected core halts.
- A cycle-count watchdog ends the run if the cores never halt.
- Sits between the test/host interface and N instances of the sequential core; generalises the single-core start/address_start stimulus to N channels with halt detection and a timeout.

Parameters:
- ADDR_W, 32, width of start address and core_addr.
- N_CORES, 1, number of controlled cores (channels), 1..16.
- CNT_W, 32, width of cycle counter.
- RST_CYCLES, 4, cycles core_rst is held before launch, >=1.
- TIMEOUT, 20000, RUN cycles before watchdog fires, >=2 and < 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  run request, single-cycle pulse.
- go_addr  in  ADDR_W  start PC for all selected cores.
- go_mask  in  N_CORES  cores to run, bit i = core i.
- abort  in  1  cancel current run.
- core_rst  out  N_CORES  per-core synchronous reset.
- core_start  out  N_CORES  per-core start pulse.
- core_addr  out  ADDR_W  address_start to all cores.
- core_halt  in  N_CORES  per-core halt indication, level or pulse.
- busy  out  1  run in progress.
- done  out  1  run finished, results valid.
- timeout  out  1  run ended by watchdog.
- halted_mask  out  N_CORES  cores seen halted in this run.
- cycle_count  out  CNT_W  RUN cycles elapsed.

Behaviour:
- Reset values: state IDLE; core_rst all ones; core_start 0; core_addr 0; busy 0; done 0; timeout 0; halted_mask 0; cycle_count 0.
- States are IDLE, RST_HOLD, LAUNCH, RUN, DONE. All outputs are registered.
- IDLE/DONE + go:
  - Latch go_addr into core_addr and go_mask into run_mask.
  - Clear done, timeout, halted_mask and cycle_count.
  - If go_mask==0: go to DONE next cycle, done=1, cycle_count=0.
  - Otherwise go to RST_HOLD with busy=1.
- go in RST_HOLD/LAUNCH/RUN is ignored.
- RST_HOLD:
  - core_rst = all ones for exactly RST_CYCLES cycles (internal counter), then LAUNCH.
  - core_addr stays stable from RST_HOLD through DONE.
- LAUNCH (one cycle):
  - core_rst = ~run_mask; unselected cores stay in reset.
  - core_start = run_mask, one-cycle pulse; zero in every other state.
  - Next state RUN.
- RUN:
  - cycle_count increments each cycle; it is 1 after the first RUN cycle and saturates at all ones.
  - halted_mask <= halted_mask | (core_halt & run_mask); halt on unselected cores is ignored.
  - If (halted_mask | (core_halt & run_mask)) == run_mask: go to DONE, done=1, busy=0.
  - Else if cycle_count == TIMEOUT-1: go to DONE, done=1, timeout=1, busy=0.
  - If both conditions hold in the same cycle, completion wins and timeout=0.
- DONE:
  - done, timeout, halted_mask and cycle_count are held.
  - core_rst = ~run_mask; halted cores are not re-reset.
  - Exit only on go (restart) or abort.
- abort in any state other than IDLE: next cycle state IDLE, core_rst all ones, busy=0, done=0, timeout=0; core_addr, halted_mask and cycle_count are held.
- abort and go in the same cycle: abort wins and go is dropped.
- rst mid-run: all outputs take reset values next cycle, including core_rst all ones.

Optional Feature:
- Macro: CPU_RUN_CTRL_STAMP_EN.
- Defined: adds output halt_stamp, N_CORES x CNT_W packed. Entry i captures the cycle_count value in the cycle core i is first seen halted. Entries are cleared to 0 on go and held in DONE; entries of unhalted cores stay 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package cpu_run_ctrl_pkg holds:
  - state enum run_state_t {IDLE, RST_HOLD, LAUNCH, RUN, DONE};
  - localparam for the RST_HOLD counter width, $clog2(RST_CYCLES+1);
  - saturating-increment function.
- One sub-module is natural: cpu_run_wdog, the cycle counter with saturation and the TIMEOUT compare, instantiated once.

Test Plan:
- Reset then go, go_addr=0, go_mask=1; core 0 asserts halt 50 cycles after the start pulse -> core_rst high 4 cycles, core_start pulse once, done=1, timeout=0, halted_mask=1, cycle_count=50.
- N_CORES=4, go_mask=4'b1011, go_addr=32'hFFFFF; halts at cycles 10, 30, 20 on cores 0, 1, 3; halt pulse on unselected core 2 -> done at cycle 30, halted_mask=4'b1011, core_addr=32'hFFFFF, core_rst[2] stays 1.
- TIMEOUT=100, core never halts -> done=1, timeout=1, cycle_count=99, halted_mask=0.
- TIMEOUT=100, core halts exactly on cycle 99 -> timeout=0, done=1.
- abort in RUN at cycle 20, go on the same cycle -> IDLE next cycle, busy=0, done=0, core_rst all ones; a later go restarts with cycle_count cleared.
- go_mask=0 -> done=1 next cycle, no core_start pulse; go during RUN is ignored and core_addr is unchanged.
